alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, response FIFO depth in entries; power of two, >= 2.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 mul, 011 {rem,quot}, 100 or, 101 and, 110 ~A, 111 ~B).
REQ-007 cmd_a  input  16  operand A.
REQ-008 cmd_b  input  16  operand B.
REQ-009 alu_a  output  16  registered operand A to the ALU.
REQ-010 alu_b  output  16  registered operand B to the ALU.
REQ-011 alu_op  output  3  registered opcode to the ALU.
REQ-012 alu_result  input  32  combinational ALU result for alu_a/alu_b/alu_op.
REQ-013 rsp_valid  output  1  FIFO head valid.
REQ-014 rsp_ready  input  1  consumer accepts head.
REQ-015 rsp_data  output  32  result at FIFO head.
REQ-016 rsp_err  output  1  head entry was divide-by-zero.
REQ-017 rsp_op  output  3  opcode of head entry.
REQ-018 busy  output  1  high when FSM in EXEC or FIFO non-empty.

Function
REQ-019 FSM states SHALL be IDLE and EXEC only; reset state IDLE.
REQ-020 cmd_ready SHALL equal (state==IDLE) && (fifo_count < DEPTH), purely from registered state.
REQ-021 Accept SHALL occur on an edge with cmd_valid && cmd_ready: cmd_a/cmd_b/cmd_op loaded into alu_a/alu_b/alu_op, IDLE -> EXEC.
REQ-022 EXEC SHALL last exactly one cycle; at its closing edge result entry written to FIFO tail, EXEC -> IDLE.
REQ-023 FIFO entry: data = alu_result, err = 0, op = alu_op; except op 011 with alu_b == 0: data = 32'h0000_0000, err = 1.
REQ-024 rsp_data SHALL pass alu_result bit-for-bit otherwise (no sign/width fixup; sub wraps mod 2^32, add/mul zero-extended per ALU).
REQ-025 Latency: accept at edge N -> entry in FIFO after edge N+1; rsp_valid high in cycle after N+1 if FIFO was empty.
REQ-026 Throughput: at most one command per two cycles.
REQ-027 FIFO pop SHALL occur on an edge with rsp_valid && rsp_ready; order strictly first-in first-out.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, both performed; pop on empty FIFO SHALL be impossible (rsp_valid low).
REQ-029 Full: no accept possible while fifo_count == DEPTH; cmd_ready rises in cycle after the pop that frees an entry.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-031 alu_a/alu_b/alu_op SHALL hold last issued values while IDLE.
REQ-032 rsp_data/rsp_err/rsp_op SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-033 rst assertion SHALL immediately (no clock) force state IDLE, FIFO empty, alu_a/alu_b/alu_op = 0, rsp_valid/rsp_data/rsp_err/rsp_op/busy = 0.
REQ-034 rst mid-EXEC SHALL discard the in-flight command; no entry written.
REQ-035 First accept SHALL be possible on the first rising edge after rst deasserts; cmd_ready = 1 throughout reset release with cmd path idle.

Verification
REQ-036 ADD: op 000, A=0x0003, B=0x0005, rsp_ready=1 -> rsp_data 0x0000_0008, rsp_err 0, rsp_op 000, rsp_valid two cycles after accept edge.
REQ-037 DIV/MUL: op 011 A=17 B=5 -> 0x0002_0003; op 010 A=0xFFFF B=0xFFFF -> 0xFFFE_0001; op 001 A=3 B=5 -> 0xFFFF_FFFE.
REQ-038 Divide-by-zero: op 011 A=9 B=0 -> rsp_data 0x0000_0000, rsp_err 1.
REQ-039 Backpressure: DEPTH=4, rsp_ready=0, 5 back-to-back commands -> exactly 4 accepted, cmd_ready 0, busy 1; release rsp_ready -> 4 results in order, then 5th accepted.
REQ-040 Simultaneous push/pop at count 1 -> count remains 1, order preserved.
REQ-041 rst pulse during EXEC -> all outputs 0 within same cycle, no stale response after release, next command returns correct result.

Source files
------------

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Issues one command at a time to an external combinational ALU and queues
//   the results in a response FIFO of DEPTH entries.
//
//   A command is accepted when cmd_valid && cmd_ready. Its operands and opcode
//   are registered onto alu_a/alu_b/alu_op and the FSM moves IDLE -> EXEC.
//   At the closing edge of the single EXEC cycle the ALU result is written to
//   the FIFO tail. A quotient/remainder opcode (011) with a zero divisor
//   stores data 0 with the error flag set, whatever the ALU drives.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/cmd_a/cmd_b           command opcode and operands
//   alu_a/alu_b/alu_op           registered operands/opcode to the ALU
//   alu_result                   combinational ALU result
//   rsp_valid/rsp_ready          response handshake (FIFO head)
//   rsp_data/rsp_err/rsp_op      head entry fields, zero while rsp_valid is 0
//   busy                         EXEC in progress or FIFO non-empty
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  rsp_op,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [2:0]    OP_DIV     = 3'b011;

  typedef enum logic {IDLE, EXEC} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [2:0]  op;
  } entry_t;

  state_e        state_q, state_d;
  logic [15:0]   alu_a_q, alu_a_d;
  logic [15:0]   alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];

  entry_t push_entry;
  entry_t head;
  logic   fifo_empty;
  logic   accept;
  logic   push;
  logic   pop;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push_entry = '{data: alu_result, err: 1'b0, op: alu_op_q};

    fifo_empty = (count_q == '0);
    cmd_ready  = (state_q == IDLE) && (count_q != FULL_COUNT);
    accept     = cmd_valid && cmd_ready;
    // The FIFO cannot fill during EXEC: the accept that started it needed a
    // free entry, and only EXEC pushes.
    push       = (state_q == EXEC);
    pop        = !fifo_empty && rsp_ready;

    if (alu_op_q == OP_DIV && alu_b_q == '0) begin
      push_entry = '{data: 32'h0000_0000, err: 1'b1, op: alu_op_q};
    end

    case (state_q)
      IDLE: if (accept) begin
        state_d  = EXEC;
        alu_a_d  = cmd_a;
        alu_b_d  = cmd_b;
        alu_op_d = cmd_op;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // visible through rsp_* after it has been written, and the outputs are
  // masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_err   = rsp_valid ? head.err  : 1'b0;
  assign rsp_op    = rsp_valid ? head.op   : '0;
  assign busy      = (state_q == EXEC) || !fifo_empty;

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule
